ov7670_sccb_config: RTL and testbench
=====================================

# ov7670_sccb_config

Power-up configuration sequencer for the OV7670 camera. Walks an external register table, issues each entry as a 3-phase SCCB write (ID 0x42, register, data), honours in-table delay entries, then raises `o_cam_done`. `o_cam_done` is the qualifier the pixel-capture block waits on before accepting its first frame. Runs in the system clock domain, not the camera `i_pclk` domain.

## Interface
- `CLK_DIV`, default 63: system clocks per SCCB quarter-bit. 25 MHz / (4·63) ≈ 99 kHz SIOC.
- `POWERUP_CYCLES`, default 25_000_000: wait after reset release before the first write.
- `DELAY_CYCLES`, default 250_000: stall length for a delay entry (10 ms at 25 MHz).
- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  single-cycle request to re-run the table from entry 0.
- `o_rom_addr`  out  8  table index.
- `i_rom_data`  in  16  table entry {reg[15:8], data[7:0]}; valid exactly 1 cycle after `o_rom_addr` changes.
- `o_sioc`  out  1  SCCB clock, driven push-pull.
- `o_siod_out`  out  1  SCCB data value.
- `o_siod_oe`  out  1  1 = drive `o_siod_out`; 0 = release (line pulled high).
- `o_busy`  out  1  high in every state except IDLE and DONE.
- `o_cam_done`  out  1  level; high after the table end is reached.

## Operation
- Reset values: `o_sioc`=1, `o_siod_out`=1, `o_siod_oe`=0, `o_rom_addr`=0, `o_busy`=0, `o_cam_done`=0.
- States:
  - PWRUP: count POWERUP_CYCLES, then go to FETCH.
  - FETCH: present `o_rom_addr`.
  - FETCH_WAIT: 1 cycle.
  - DECODE:
    - 0xFFFF goes to DONE.
    - 0xFFF0 goes to DELAY.
    - Any other value latches reg/data and goes to START.
  - DELAY: count DELAY_CYCLES, then `o_rom_addr`+1 and go to FETCH.
  - START, BITS, STOP, GAP: see Timing. After GAP, go to FETCH with addr+1.
  - DONE: `o_cam_done`=1, bus idle.
  - IDLE: unused after the first run; reserved.
- Shift sequence: 27 bit slots, MSB first: 0x42, don't-care, reg, don't-care, data, don't-care.
  - Data slots: `o_siod_oe`=1.
  - Don't-care slots: `o_siod_oe`=0. The ACK value is not sampled and there is no error path.
- Table end:
  - 0xFFFF ends the run.
  - If entry 255 is an ordinary write, DONE follows its GAP. No address wrap.
  - A delay entry at 255 also goes to DONE after the delay.
- `i_start`:
  - Honoured only in DONE: clears `o_cam_done` the next cycle, sets `o_rom_addr`=0, goes to FETCH (no PWRUP wait).
  - Ignored while `o_busy`=1. It is not queued.
- Reset mid-transaction: all outputs go to reset values immediately (asynchronously), releasing SIOD mid-byte. On release, the sequence restarts from PWRUP.

## Timing
- Quarter tick Q = CLK_DIV cycles; all SCCB edges align to Q boundaries.
- START, 2Q:
  - Q0: SIOC=1, SIOD driven 1.
  - Q1: SIOD driven 0, SIOC=1. This is the start condition.
- Each bit slot, 4Q:
  - SIOD updates at the start of Q0.
  - SIOC=0 in Q0–Q1 and 1 in Q2–Q3.
  - The SIOC falling edge coincides with the next slot's Q0.
- STOP, 3Q:
  - Q0: SIOC=0, SIOD driven 0.
  - Q1: SIOC=1, SIOD 0.
  - Q2: SIOD driven 1 while SIOC=1. This is the stop condition.
- GAP, 4Q: SIOC=1, `o_siod_oe`=0.
- Write length: 2+108+3+4 = 117Q from the first START cycle to the end of GAP.
- Entry overhead: 3 cycles (FETCH, FETCH_WAIT, DECODE) before START, DELAY or DONE.
- Delay entry: 3 + DELAY_CYCLES cycles.
- `o_cam_done` rises on the cycle DONE is entered. `o_busy` falls the same cycle.
- Counter widths are sized from the parameters: ceil(log2(max+1)). No counter may wrap inside a state.

## Test plan
All scenarios use CLK_DIV=2, POWERUP_CYCLES=10, DELAY_CYCLES=20.

1. Table {0x1280, 0xFFFF}, release reset.
   - SIOC/SIOD idle for 10 cycles.
   - One write decodes as 0x42, 0x12, 0x80, with `o_siod_oe`=0 in slots 9, 18 and 27.
   - `o_cam_done` rises 10+3+234+3 = 250 cycles after reset release.
2. Table {0x1280, 0xFFF0, 0x1104, 0xFFFF}.
   - Gap between the end of the first GAP and the second START = 3+20+3 = 26 cycles.
   - Both writes decode correctly.
3. Start/stop edges: assert SIOD falls while SIOC=1 exactly once per write, and SIOD rises while SIOC=1 exactly once per write. No other SIOD change while SIOC=1.
4. Pulse `i_start` mid-write, then again in DONE.
   - The first pulse has no effect.
   - The second clears `o_cam_done` next cycle and replays the table without the PWRUP wait.
5. Table of 256 ordinary writes with no end marker: DONE after the write at entry 255; `o_rom_addr` never returns to 0.
6. Assert `i_rst` during bit slot 12.
   - Outputs return to reset values without a clock edge.
   - After release, the sequence restarts with the 10-cycle PWRUP and entry 0.

Source files
------------

// File: rtl/ov7670_sccb_config.sv
// rtl/ov7670_sccb_config.sv - OV7670 power-up register table sequencer over SCCB
module ov7670_sccb_config #(
  parameter int CLK_DIV        = 63,
  parameter int POWERUP_CYCLES = 25_000_000,
  parameter int DELAY_CYCLES   = 250_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sioc,
  output logic        o_siod_out,
  output logic        o_siod_oe,
  output logic        o_busy,
  output logic        o_cam_done
);

  localparam int WAIT_MAX = (POWERUP_CYCLES > DELAY_CYCLES) ? POWERUP_CYCLES : DELAY_CYCLES;
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam int QW = $clog2(CLK_DIV + 1);
  localparam logic [WW-1:0] PWR_LAST = WW'(POWERUP_CYCLES - 1);
  localparam logic [WW-1:0] DLY_LAST = WW'(DELAY_CYCLES - 1);
  localparam logic [QW-1:0] Q_LAST   = QW'(CLK_DIV - 1);
  localparam logic [7:0]    SCCB_ID  = 8'h42;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_FETCH_WAIT, S_DECODE, S_DELAY,
    S_START, S_BITS, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic [QW-1:0]   q_cnt;
  logic [1:0]      q_ph;
  logic [4:0]      slot;
  logic [26:0]     shreg;
  logic            q_tick;

  assign q_tick = (q_cnt == Q_LAST);

  // The ninth slot of each phase is the slave ACK; the line is released there.
  function automatic logic slot_is_ack(input logic [4:0] s);
    return (s == 5'd8) || (s == 5'd17) || (s == 5'd26);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_PWRUP;
      wait_cnt   <= '0;
      q_cnt      <= '0;
      q_ph       <= '0;
      slot       <= '0;
      shreg      <= '0;
      o_rom_addr <= '0;
      o_sioc     <= 1'b1;
      o_siod_out <= 1'b1;
      o_siod_oe  <= 1'b0;
      o_busy     <= 1'b0;
      o_cam_done <= 1'b0;
    end else begin
      case (state)
        S_PWRUP: begin
          o_busy <= 1'b1;
          if (wait_cnt == PWR_LAST) begin
            wait_cnt <= '0;
            state    <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_FETCH:      state <= S_FETCH_WAIT;
        S_FETCH_WAIT: state <= S_DECODE;
        S_DECODE: begin
          if (i_rom_data == 16'hFFFF) begin
            state      <= S_DONE;
            o_busy     <= 1'b0;
            o_cam_done <= 1'b1;
          end else if (i_rom_data == 16'hFFF0) begin
            state    <= S_DELAY;
            wait_cnt <= '0;
          end else begin
            state      <= S_START;
            shreg      <= {SCCB_ID, 1'b0, i_rom_data[15:8], 1'b0, i_rom_data[7:0], 1'b0};
            q_cnt      <= '0;
            q_ph       <= '0;
            o_sioc     <= 1'b1;
            o_siod_oe  <= 1'b1;
            o_siod_out <= 1'b1;
          end
        end
        S_DELAY: begin
          if (wait_cnt == DLY_LAST) begin
            wait_cnt <= '0;
            if (o_rom_addr == 8'hFF) begin
              state      <= S_DONE;
              o_busy     <= 1'b0;
              o_cam_done <= 1'b1;
            end else begin
              o_rom_addr <= o_rom_addr + 8'd1;
              state      <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_START: begin
          q_cnt <= q_tick ? '0 : q_cnt + QW'(1);
          if (q_tick) begin
            if (q_ph == 2'd0) begin
              q_ph       <= 2'd1;
              o_siod_out <= 1'b0;
            end else begin
              state      <= S_BITS;
              q_ph       <= 2'd0;
              slot       <= '0;
              o_sioc     <= 1'b0;
              o_siod_oe  <= 1'b1;
              o_siod_out <= shreg[26];
            end
          end
        end
        S_BITS: begin
          q_cnt <= q_tick ? '0 : q_cnt + QW'(1);
          if (q_tick) begin
            q_ph <= q_ph + 2'd1;
            if (q_ph == 2'd1) begin
              o_sioc <= 1'b1;
            end else if (q_ph == 2'd3) begin
              o_sioc <= 1'b0;
              if (slot == 5'd26) begin
                state      <= S_STOP;
                o_siod_oe  <= 1'b1;
                o_siod_out <= 1'b0;
              end else begin
                slot       <= slot + 5'd1;
                shreg      <= {shreg[25:0], 1'b0};
                o_siod_oe  <= !slot_is_ack(slot + 5'd1);
                o_siod_out <= shreg[25];
              end
            end
          end
        end
        S_STOP: begin
          q_cnt <= q_tick ? '0 : q_cnt + QW'(1);
          if (q_tick) begin
            if (q_ph == 2'd0) begin
              q_ph   <= 2'd1;
              o_sioc <= 1'b1;
            end else if (q_ph == 2'd1) begin
              q_ph       <= 2'd2;
              o_siod_out <= 1'b1;
            end else begin
              state     <= S_GAP;
              q_ph      <= 2'd0;
              o_siod_oe <= 1'b0;
            end
          end
        end
        S_GAP: begin
          q_cnt <= q_tick ? '0 : q_cnt + QW'(1);
          if (q_tick) begin
            if (q_ph == 2'd3) begin
              q_ph <= 2'd0;
              // Entry 255 is the last slot of the table; never wrap back to 0.
              if (o_rom_addr == 8'hFF) begin
                state      <= S_DONE;
                o_busy     <= 1'b0;
                o_cam_done <= 1'b1;
              end else begin
                o_rom_addr <= o_rom_addr + 8'd1;
                state      <= S_FETCH;
              end
            end else begin
              q_ph <= q_ph + 2'd1;
            end
          end
        end
        S_DONE: begin
          if (i_start) begin
            o_cam_done <= 1'b0;
            o_busy     <= 1'b1;
            o_rom_addr <= '0;
            state      <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb/tb_ov7670_sccb_config.sv - randomized bench for ov7670_sccb_config against a table-walk model
module tb_ov7670_sccb_config;

  localparam int CLK_DIV = 2;
  localparam int PWR     = 10;
  localparam int DLY     = 20;
  localparam int WR_CYC  = 117 * CLK_DIV;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sioc, siod_out, siod_oe, busy, cam_done;
  logic        line;
  logic [15:0] rom [256];

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  assign line = siod_oe ? siod_out : 1'b1;

  ov7670_sccb_config #(.CLK_DIV(CLK_DIV), .POWERUP_CYCLES(PWR), .DELAY_CYCLES(DLY)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_sioc(sioc), .o_siod_out(siod_out), .o_siod_oe(siod_oe), .o_busy(busy), .o_cam_done(cam_done)
  );

  // SCCB bus monitor: decodes frames from start/stop conditions and SIOC rising edges.
  int          cyc = 0;
  int          m_nbits = 0, m_nstart = 0, m_nstop = 0, m_badedge = 0;
  logic [23:0] got_w [$];
  logic [26:0] got_oe [$];
  int          start_cyc [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic prev_sioc, prev_line, in_frame;
    logic [26:0] bits, oes;
    prev_sioc = 1'b1; prev_line = 1'b1; in_frame = 1'b0; bits = '0; oes = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        m_nbits  = 0;
      end else begin
        if (prev_sioc && sioc && line != prev_line) begin
          if (!line && !in_frame) begin
            in_frame = 1'b1; m_nbits = 0; m_nstart++; start_cyc.push_back(cyc);
          end else if (line && in_frame && m_nbits == 28) begin
            in_frame = 1'b0; m_nstop++;
            got_w.push_back({bits[26:19], bits[17:10], bits[8:1]});
            got_oe.push_back(oes);
          end else begin
            m_badedge++;
          end
        end
        if (in_frame && !prev_sioc && sioc) begin
          if (m_nbits < 27) begin
            bits = {bits[25:0], line};
            oes  = {oes[25:0], siod_oe};
          end
          m_nbits++;
        end
      end
      prev_sioc = sioc;
      prev_line = line;
    end
  end

  int          n_cmp = 0, n_bad = 0;
  logic [23:0] exp_w [$];
  logic [26:0] exp_oe;
  int          exp_t;
  int          run_cyc;
  bit          idle_bad, addr_wrap, seen_nz;
  int          b_w, b_start, b_stop, b_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the table with the documented per-entry costs.
  task automatic model(input int t0);
    int t;
    t = t0;
    exp_w.delete();
    for (int i = 0; i < 256; i++) begin
      t += 3;
      if (rom[i] == 16'hFFFF) break;
      if (rom[i] == 16'hFFF0) t += DLY;
      else begin
        t += WR_CYC;
        exp_w.push_back({8'h42, rom[i]});
      end
    end
    exp_t = t;
  endtask

  function automatic logic [15:0] rand_write();
    logic [15:0] v;
    v = 16'($urandom);
    if (v == 16'hFFFF || v == 16'hFFF0) v[0] = ~v[0];
    return v;
  endfunction

  task automatic snap();
    b_w = got_w.size(); b_start = m_nstart; b_stop = m_nstop; b_bad = m_badedge;
  endtask

  task automatic wait_done(input int first, input int idle_n, input int poke_at);
    int budget;
    budget = exp_t + 100;
    run_cyc = first; idle_bad = 0; addr_wrap = 0; seen_nz = 0;
    while (!cam_done && run_cyc < budget) begin
      @(negedge clk);
      start = (run_cyc == poke_at);
      run_cyc++;
      if (run_cyc <= idle_n && !(sioc && line)) idle_bad = 1;
      if (rom_addr != 8'd0) seen_nz = 1;
      else if (seen_nz) addr_wrap = 1;
    end
    start = 1'b0;
    check("done_seen", cam_done, 1);
    check("done_cycle", run_cyc, exp_t);
    check("busy_at_done", busy, 0);
  endtask

  task automatic verify_writes();
    int n;
    n = got_w.size() - b_w;
    check("write_count", n, exp_w.size());
    check("start_count", m_nstart - b_start, exp_w.size());
    check("stop_count", m_nstop - b_stop, exp_w.size());
    check("siod_change_while_sioc_high", m_badedge - b_bad, 0);
    for (int i = 0; i < exp_w.size() && i < n; i++) begin
      check("write_bytes", got_w[b_w + i], exp_w[i]);
      check("ack_release", got_oe[b_w + i], exp_oe);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_clear", cam_done, 0);
    check("addr_restart", rom_addr, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sioc"}, sioc, 1);
    check({tag, "_siod_out"}, siod_out, 1);
    check({tag, "_siod_oe"}, siod_oe, 0);
    check({tag, "_addr"}, rom_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, cam_done, 0);
  endtask

  initial begin
    int n, gap;
    exp_oe = '0;
    for (int s = 1; s <= 27; s++) exp_oe = {exp_oe[25:0], (s % 9 != 0)};
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Single write then end marker, from power-up.
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    model(PWR); snap();
    rst = 1'b0;
    wait_done(0, 12, -1);
    check("powerup_idle", idle_bad, 0);
    check("done_at_250", run_cyc, 250);
    verify_writes();

    // Write, delay, write: replayed through i_start with no power-up wait.
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1104; rom[3] = 16'hFFFF;
    model(1); snap();
    restart();
    wait_done(1, 0, -1);
    verify_writes();
    gap = (start_cyc.size() >= b_start + 2) ? start_cyc[b_start + 1] - start_cyc[b_start] : -1;
    check("delay_start_gap", gap, WR_CYC + 3 + DLY + 3);

    // Random tables; the first replay also pulses i_start mid-run.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      n = $urandom_range(2, 6);
      rom[0] = rand_write();
      for (int i = 1; i < n; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 16'hFFF0 : rand_write();
      model(1); snap();
      restart();
      wait_done(1, 0, (r == 0) ? 50 : -1);
      verify_writes();
    end

    // Full 256-entry table with no end marker.
    for (int i = 0; i < 256; i++) rom[i] = rand_write();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    model(PWR); snap();
    rst = 1'b0;
    wait_done(0, 12, -1);
    check("addr_no_wrap", addr_wrap, 0);
    check("addr_final", rom_addr, 8'hFF);
    verify_writes();

    // Asynchronous reset in the middle of bit slot 12.
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (m_nbits != 12 && n < 400);
    check("reached_slot12", m_nbits, 12);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    model(PWR); snap();
    rst = 1'b0;
    wait_done(0, 12, -1);
    check("restart_idle", idle_bad, 0);
    verify_writes();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
